// File: rtl/lfsr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_seq_ctrl
//
// Purpose:
//   Sequencing controller plus the 8-bit right-shift register it owns.
//   A requester hands over a job (mode, seed, step count) with a start
//   pulse while the block is idle. The seed is parallel-loaded, then the
//   register is shifted exactly `count` times, one shift per clock. The
//   shift-in bit is either the serial input (mode 0) or LFSR feedback from
//   taps 0,1,2,5 (mode 1). Completion is flagged by a one-cycle done pulse.
//   A running job can be cancelled with abort, which leaves the partial
//   result in the register and produces no done pulse.
//
// Ports:
//   CLK        in   1      clock, rising-edge active
//   rst        in   1      asynchronous reset, active low
//   start      in   1      job request, sampled only while idle
//   mode       in   1      0 = serial shift from sin, 1 = LFSR feedback
//   seed       in   W      parallel load value, captured with start
//   count      in   CNT_W  number of shifts, captured with start
//   sin        in   1      serial input bit, used in mode 0 while running
//   abort      in   1      cancel the running job
//   busy       out  1      high whenever a job is in progress or completing
//   done       out  1      one-cycle completion pulse
//   data       out  W      current register contents
//   steps_left out  CNT_W  shifts still to perform
//   lockup     out  1      seed-0 LFSR load was corrected (0 without macro)
//
// Configuration:
//   LFSR_LOCKUP_FIX_EN - when defined, an LFSR job started with seed 0 loads
//   8'h01 instead (the all-zero state never leaves itself) and raises lockup
//   until the next accepted start. When undefined, seed 0 is loaded as-is
//   and lockup is tied low.
// ---------------------------------------------------------------------------
module lfsr_seq_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [W-1:0]     seed,
  input  logic [CNT_W-1:0] count,
  input  logic             sin,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     data,
  output logic [CNT_W-1:0] steps_left,
  output logic             lockup
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fb;

`ifdef LFSR_LOCKUP_FIX_EN
  logic             lockup_q, lockup_d;
  logic             seed_is_lockup;

  // An LFSR job seeded with all zeros would never leave zero.
  assign seed_is_lockup = mode && (seed == '0);
`endif

  // Feedback bit for the next shift. Mode is taken from the latched copy so
  // that a requester changing mode mid-job cannot disturb the sequence.
  always_comb begin
    fb = sin;
    if (mode_q) begin
      fb = data_q[0] ^ data_q[1] ^ data_q[2] ^ data_q[5];
    end
  end

  // Next-state and datapath logic. busy/done are derived from the next
  // state so they come out of flops aligned with the state register.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    steps_d = steps_q;
    mode_d  = mode_q;
`ifdef LFSR_LOCKUP_FIX_EN
    lockup_d = lockup_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = seed;
          mode_d  = mode;
          steps_d = count;
          state_d = (count != '0) ? RUN : DONE;
`ifdef LFSR_LOCKUP_FIX_EN
          lockup_d = seed_is_lockup;
          if (seed_is_lockup) begin
            data_d = W'(1);
          end
`endif
        end
      end

      RUN: begin
        // Abort takes priority even over the final shift.
        if (abort) begin
          steps_d = '0;
          state_d = IDLE;
        end else begin
          data_d  = {fb, data_q[W-1:1]};
          steps_d = steps_q - CNT_W'(1);
          if (steps_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      steps_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LFSR_LOCKUP_FIX_EN
      lockup_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      steps_q <= steps_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LFSR_LOCKUP_FIX_EN
      lockup_q <= lockup_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign data       = data_q;
  assign steps_left = steps_q;
`ifdef LFSR_LOCKUP_FIX_EN
  assign lockup     = lockup_q;
`else
  assign lockup     = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_seq_ctrl
//
// Directed bench for lfsr_seq_ctrl: LFSR job, serial job, zero-count job,
// abort (including abort on the final shift), ignored start while busy,
// asynchronous reset mid-job, and the seed-0 LFSR case with or without
// LFSR_LOCKUP_FIX_EN.
// ---------------------------------------------------------------------------
module tb_lfsr_seq_ctrl;

  logic       CLK;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] seed;
  logic [7:0] count;
  logic       sin;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] data;
  logic [7:0] steps_left;
  logic       lockup;

  int compareCount = 0;
  int failCount    = 0;

  lfsr_seq_ctrl #(.W(8), .CNT_W(8)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
    .count      (count),
    .sin        (sin),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .data       (data),
    .steps_left (steps_left),
    .lockup     (lockup)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive every job-related input in one go.
  task automatic applyStimulus(input logic st, input logic md, input logic [7:0] sd,
                               input logic [7:0] cn, input logic si, input logic ab);
    start = st;
    mode  = md;
    seed  = sd;
    count = cn;
    sin   = si;
    abort = ab;
  endtask

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Check the full visible status in one call.
  task automatic checkAll(input string tag, input logic [7:0] expData, input logic [7:0] expSteps,
                          input logic expBusy, input logic expDone);
    checkOutput({tag, ".data"}, 32'(data), 32'(expData));
    checkOutput({tag, ".steps"}, 32'(steps_left), 32'(expSteps));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
    checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
  endtask

  initial begin
    logic [7:0] expSerial;

    // Reset state.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkAll("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("reset.lockup", 32'(lockup), 32'd0);
    #1;
    rst = 1'b1;

    // LFSR job: seed 01, three shifts -> 80, 40, 20.
    $display("[TB] LFSR job");
    applyStimulus(1'b1, 1'b1, 8'h01, 8'd3, 1'b0, 1'b0);
    tick();
    checkAll("lfsr.E0", 8'h01, 8'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h5A, 8'd9, 1'b0, 1'b0);
    tick();
    checkAll("lfsr.E1", 8'h80, 8'd2, 1'b1, 1'b0);
    tick();
    checkAll("lfsr.E2", 8'h40, 8'd1, 1'b1, 1'b0);
    tick();
    checkAll("lfsr.E3", 8'h20, 8'd0, 1'b1, 1'b1);
    tick();
    checkAll("lfsr.after", 8'h20, 8'd0, 1'b0, 1'b0);

    // Serial job: eight 1s shifted in; mode flipped mid-job must not matter.
    $display("[TB] serial job");
    applyStimulus(1'b1, 1'b0, 8'h00, 8'd8, 1'b1, 1'b0);
    tick();
    checkAll("ser.E0", 8'h00, 8'd8, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'd0, 1'b1, 1'b0);
    expSerial = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      expSerial = {1'b1, expSerial[7:1]};
      checkOutput("ser.data", 32'(data), 32'(expSerial));
      checkOutput("ser.steps", 32'(steps_left), 32'(8 - i));
      checkOutput("ser.done", 32'(done), 32'(i == 8));
    end
    checkOutput("ser.final", 32'(data), 32'hFF);
    tick();
    checkAll("ser.after", 8'hFF, 8'd0, 1'b0, 1'b0);

    // Zero count: straight to DONE, no shift.
    $display("[TB] zero-count job");
    applyStimulus(1'b1, 1'b0, 8'hA5, 8'd0, 1'b0, 1'b0);
    tick();
    checkAll("zero.E0", 8'hA5, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    checkAll("zero.after", 8'hA5, 8'd0, 1'b0, 1'b0);

    // Abort after two shifts; a start while busy is ignored.
    $display("[TB] abort job");
    applyStimulus(1'b1, 1'b1, 8'h01, 8'd5, 1'b0, 1'b0);
    tick();
    checkAll("abort.E0", 8'h01, 8'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'd5, 1'b0, 1'b0);
    tick();
    checkAll("abort.E1", 8'h80, 8'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'd2, 1'b0, 1'b0);
    tick();
    checkAll("abort.busyStart", 8'h40, 8'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1);
    tick();
    checkAll("abort.E3", 8'h40, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1);
    tick();
    checkAll("abort.idle", 8'h40, 8'd0, 1'b0, 1'b0);

    // Abort coinciding with the last shift: abort wins, no done.
    $display("[TB] abort on final shift");
    applyStimulus(1'b1, 1'b1, 8'h01, 8'd1, 1'b0, 1'b0);
    tick();
    checkAll("abortLast.E0", 8'h01, 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'd1, 1'b0, 1'b1);
    tick();
    checkAll("abortLast.E1", 8'h01, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);

    // Reset mid-run after three serial shifts, then a normal job.
    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b0, 8'h00, 8'd8, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkAll("rstRun.E3", 8'hE0, 8'd5, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    checkAll("rstRun.async", 8'h00, 8'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h01, 8'd2, 1'b0, 1'b0);
    tick();
    checkAll("rstRun.newE0", 8'h01, 8'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    checkAll("rstRun.newE1", 8'h80, 8'd1, 1'b1, 1'b0);
    tick();
    checkAll("rstRun.newE2", 8'h40, 8'd0, 1'b1, 1'b1);
    tick();
    checkAll("rstRun.newAfter", 8'h40, 8'd0, 1'b0, 1'b0);

    // Seed-0 LFSR job.
    $display("[TB] seed-0 LFSR job");
    applyStimulus(1'b1, 1'b1, 8'h00, 8'd3, 1'b0, 1'b0);
    tick();
`ifdef LFSR_LOCKUP_FIX_EN
    checkAll("lock.E0", 8'h01, 8'd3, 1'b1, 1'b0);
    checkOutput("lock.E0.lockup", 32'(lockup), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    checkAll("lock.E1", 8'h80, 8'd2, 1'b1, 1'b0);
    tick();
    checkAll("lock.E2", 8'h40, 8'd1, 1'b1, 1'b0);
    tick();
    checkAll("lock.E3", 8'h20, 8'd0, 1'b1, 1'b1);
    tick();
    checkOutput("lock.held", 32'(lockup), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h01, 8'd0, 1'b0, 1'b0);
    tick();
    checkOutput("lock.cleared", 32'(lockup), 32'd0);
    checkOutput("lock.newData", 32'(data), 32'h01);
`else
    checkAll("lock.E0", 8'h00, 8'd3, 1'b1, 1'b0);
    checkOutput("lock.E0.lockup", 32'(lockup), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    checkAll("lock.E1", 8'h00, 8'd2, 1'b1, 1'b0);
    tick();
    checkAll("lock.E2", 8'h00, 8'd1, 1'b1, 1'b0);
    tick();
    checkAll("lock.E3", 8'h00, 8'd0, 1'b1, 1'b1);
    checkOutput("lock.E3.lockup", 32'(lockup), 32'd0);
    tick();
`endif
    applyStimulus(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
